halt_reporter: RTL and testbench
================================

HALT_REPORTER -- requirements
Module: halt_reporter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter CONFIRM_CYCLES, default 5: cycles halt must hold before reporting.
REQ-003 SHALL have parameter TIMEOUT, default 1000: cycle limit for first halt; 0 disables the timeout.
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 halt  input  1  core halt indication, level.
REQ-007 firstWord  input  16  core result word, sampled with halt.
REQ-008 tx  output  1  serial report line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while a frame is being shifted out.
REQ-010 done  output  1  high once the frame has been fully sent; sticky until rst.

Function
REQ-011 SHALL keep a 32-bit cycle counter cnt: 0 in reset, +1 every non-reset cycle, saturating at 0xFFFFFFFF.
REQ-012 SHALL implement states WAIT_HALT, CONFIRM, SEND, DONE; reset state WAIT_HALT.
REQ-013 WAIT_HALT: first cycle with halt=1 SHALL capture firstWord into word_q and cnt+1 into cnt_q, then go to CONFIRM.
REQ-014 WAIT_HALT: if TIMEOUT!=0 and cnt+1 > TIMEOUT with halt=0, SHALL set status TIMEOUT, set word_q=0 and cnt_q=cnt+1, and go to SEND.
REQ-015 WAIT_HALT: halt=1 in the same cycle as the timeout threshold SHALL take the halt path (REQ-013).
REQ-016 CONFIRM: each cycle SHALL check halt=1 and firstWord==word_q; the first failure sets DEASSERT (halt=0) or WORDCHG (word differs); if both fail together, both bits are set. Any failure goes to SEND.
REQ-017 CONFIRM: after CONFIRM_CYCLES passing cycles, SHALL set status OK, set cnt_q=cnt_q+CONFIRM_CYCLES, and go to SEND.
REQ-018 SEND SHALL transmit 8 bytes: 0xA5, status, word_q[15:8], word_q[7:0], cnt_q[31:24], [23:16], [15:8], [7:0].
REQ-019 Each byte SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit CLKS_PER_BIT cycles, with no idle gap between bytes.
REQ-020 Frame length SHALL be exactly 80*CLKS_PER_BIT cycles; tx goes low in the first SEND cycle.
REQ-021 busy SHALL be 1 for exactly the SEND cycles. done SHALL rise in the cycle after the last stop bit, and the FSM enters DONE.
REQ-022 DONE SHALL ignore halt and firstWord and hold tx=1, busy=0, done=1.
REQ-023 Status byte: bit0 OK, bit1 DEASSERT, bit2 WORDCHG, bit3 TIMEOUT, bits7:4 zero.
REQ-024 After CONFIRM or a timeout, halt and firstWord SHALL NOT affect the frame.

Reset
REQ-025 rst SHALL force tx=1, busy=0, done=0, cnt=0, word_q=0, cnt_q=0, status=0, state WAIT_HALT.
REQ-026 rst asserted mid-frame SHALL abort within the same edge, with tx=1 on the next cycle and no partial byte resumed.
REQ-027 rst has priority over all other events.

Structure
REQ-028 Package halt_report_pkg SHALL hold the state enum, SYNC_BYTE=0xA5, status bit indices, and FRAME_BYTES=8.
REQ-029 Byte serialisation SHALL be a sub-module uart_tx_byte (clk, rst, start, data[7:0], tx, ready), parameterised by CLKS_PER_BIT.

Verification (CLKS_PER_BIT=4, CONFIRM_CYCLES=5, TIMEOUT=1000)
REQ-030 Release rst, raise halt at cycle 37 with firstWord=0x1234 held steady -> frame A5 01 12 34 00 00 00 2A; done rises 320 cycles after SEND entry.
REQ-031 Halt at cycle 10, drop halt at cycle 12 -> status 0x02, count 0x0000000A.
REQ-032 Halt at cycle 10 with word 0x00FF, change to 0x00FE at cycle 13 -> status 0x04, word bytes 00 FF.
REQ-033 halt never asserted -> SEND entered with cnt_q=1001; frame A5 08 00 00 00 00 03 E9.
REQ-034 Assert rst at byte 3 of a frame -> tx=1 and busy=0 next cycle; a later halt produces a clean full frame.
REQ-035 Halt first asserted exactly at cycle 1001 -> halt path, status 0x01, no timeout.

Source files
------------

// File: rtl/halt_report_pkg.sv
// Shared types and constants for the halt reporter: FSM states, frame layout
// and status byte bit positions.
package halt_report_pkg;

    typedef enum logic [1:0] {
        WAIT_HALT = 2'd0,
        CONFIRM   = 2'd1,
        SEND      = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 8;

    localparam int ST_OK       = 0;
    localparam int ST_DEASSERT = 1;
    localparam int ST_WORDCHG  = 2;
    localparam int ST_TIMEOUT  = 3;

    // Byte idx of the report frame: sync, status, word MSB first, count MSB first.
    function automatic logic [7:0] frameByte(input logic [3:0]  idx,
                                             input logic [7:0]  status,
                                             input logic [15:0] word,
                                             input logic [31:0] count);
        logic [7:0] b;
        b = SYNC_BYTE;
        case (idx)
            4'd0:    b = SYNC_BYTE;
            4'd1:    b = status;
            4'd2:    b = word[15:8];
            4'd3:    b = word[7:0];
            4'd4:    b = count[31:24];
            4'd5:    b = count[23:16];
            4'd6:    b = count[15:8];
            4'd7:    b = count[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/halt_reporter_uart.sv
// 8N1 byte serialiser. ready is also high in the final stop-bit cycle so the
// next byte can follow back to back without an idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);
    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  STOP_BIT  = 4'd9;

    logic        active_r;
    logic [3:0]  bitIdx_r;
    logic [15:0] tick_r;
    logic [7:0]  data_r;
    logic        tx_r;
    logic [3:0]  nextBit_s;

    assign nextBit_s = bitIdx_r + 4'd1;
    assign ready     = !active_r || ((bitIdx_r == STOP_BIT) && (tick_r == LAST_TICK));
    assign tx        = tx_r;

    // Bit timing and shift: position 0 is start, 1..8 data LSB first, 9 stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r     <= 1'b1;
            active_r <= 1'b0;
            bitIdx_r <= 4'd0;
            tick_r   <= 16'd0;
            data_r   <= 8'd0;
        end else if (start && ready) begin
            tx_r     <= 1'b0;
            active_r <= 1'b1;
            bitIdx_r <= 4'd0;
            tick_r   <= 16'd0;
            data_r   <= data;
        end else if (active_r && (tick_r == LAST_TICK)) begin
            tick_r <= 16'd0;
            if (bitIdx_r == STOP_BIT) begin
                active_r <= 1'b0;
                tx_r     <= 1'b1;
            end else begin
                bitIdx_r <= nextBit_s;
                tx_r     <= (nextBit_s == STOP_BIT) ? 1'b1 : data_r[3'(nextBit_s - 4'd1)];
            end
        end else if (active_r) begin
            tick_r <= tick_r + 16'd1;
        end else begin
            tick_r <= tick_r;
        end
    end

endmodule

// File: rtl/halt_reporter.sv
// Waits for the core to halt, confirms the halt is stable, then reports the
// result word and cycle count as an 8-byte serial frame.
module halt_reporter
    import halt_report_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 16,
    parameter int CONFIRM_CYCLES = 5,
    parameter int TIMEOUT        = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [15:0] firstWord,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    state_t      state_r, nextState_s;
    logic [31:0] cnt_r, cntPlus1_s;
    logic [15:0] wordQ_r, wordQ_s;
    logic [31:0] cntQ_r, cntQ_s;
    logic [7:0]  status_r, status_s;
    logic [31:0] confirmCnt_r, confirmCnt_s;
    logic [3:0]  byteIdx_r, byteIdx_s;
    logic        busy_r, done_r;
    logic        txStart_s, txReady_s;
    logic [7:0]  txData_s;

    assign cntPlus1_s = (cnt_r == 32'hFFFF_FFFF) ? cnt_r : cnt_r + 32'd1;
    assign busy       = busy_r;
    assign done       = done_r;

    // Next-state logic; the transition into SEND also launches the sync byte
    // so tx is already low in the first SEND cycle.
    always_comb begin
        nextState_s  = state_r;
        wordQ_s      = wordQ_r;
        cntQ_s       = cntQ_r;
        status_s     = status_r;
        confirmCnt_s = confirmCnt_r;
        byteIdx_s    = byteIdx_r;
        txStart_s    = 1'b0;
        txData_s     = SYNC_BYTE;
        case (state_r)
            WAIT_HALT: begin
                if (halt) begin
                    wordQ_s      = firstWord;
                    cntQ_s       = cntPlus1_s;
                    confirmCnt_s = 32'd0;
                    nextState_s  = CONFIRM;
                end else if ((TIMEOUT != 0) && (cntPlus1_s > 32'(TIMEOUT))) begin
                    status_s              = 8'd0;
                    status_s[ST_TIMEOUT]  = 1'b1;
                    wordQ_s               = 16'd0;
                    cntQ_s                = cntPlus1_s;
                    byteIdx_s             = 4'd1;
                    txStart_s             = 1'b1;
                    nextState_s           = SEND;
                end else begin
                    nextState_s = WAIT_HALT;
                end
            end
            CONFIRM: begin
                if (!halt || (firstWord != wordQ_r)) begin
                    status_s              = 8'd0;
                    status_s[ST_DEASSERT] = !halt;
                    status_s[ST_WORDCHG]  = (firstWord != wordQ_r);
                    byteIdx_s             = 4'd1;
                    txStart_s             = 1'b1;
                    nextState_s           = SEND;
                end else if (confirmCnt_r == 32'(CONFIRM_CYCLES - 1)) begin
                    status_s         = 8'd0;
                    status_s[ST_OK]  = 1'b1;
                    cntQ_s           = cntQ_r + 32'(CONFIRM_CYCLES);
                    byteIdx_s        = 4'd1;
                    txStart_s        = 1'b1;
                    nextState_s      = SEND;
                end else begin
                    confirmCnt_s = confirmCnt_r + 32'd1;
                end
            end
            SEND: begin
                if (txReady_s && (byteIdx_r == 4'(FRAME_BYTES))) begin
                    nextState_s = DONE;
                end else if (txReady_s) begin
                    txStart_s = 1'b1;
                    txData_s  = frameByte(byteIdx_r, status_r, wordQ_r, cntQ_r);
                    byteIdx_s = byteIdx_r + 4'd1;
                end else begin
                    nextState_s = SEND;
                end
            end
            DONE: begin
                nextState_s = DONE;
            end
            default: begin
                nextState_s = WAIT_HALT;
            end
        endcase
    end

    // State, capture registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= WAIT_HALT;
            cnt_r        <= 32'd0;
            wordQ_r      <= 16'd0;
            cntQ_r       <= 32'd0;
            status_r     <= 8'd0;
            confirmCnt_r <= 32'd0;
            byteIdx_r    <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= nextState_s;
            cnt_r        <= cntPlus1_s;
            wordQ_r      <= wordQ_s;
            cntQ_r       <= cntQ_s;
            status_r     <= status_s;
            confirmCnt_r <= confirmCnt_s;
            byteIdx_r    <= byteIdx_s;
            busy_r       <= (nextState_s == SEND);
            done_r       <= (nextState_s == DONE);
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uTx (
        .clk   (clk),
        .rst   (rst),
        .start (txStart_s),
        .data  (txData_s),
        .tx    (tx),
        .ready (txReady_s)
    );

endmodule

// File: tb/tb_halt_reporter.sv
// Directed bench for halt_reporter with CLKS_PER_BIT=4: frames are sampled
// mid-bit and compared against hand-computed byte sequences.
module tb_halt_reporter;
    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic [15:0] firstWord;
    logic        tx, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    halt_reporter #(
        .CLKS_PER_BIT   (4),
        .CONFIRM_CYCLES (5),
        .TIMEOUT        (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .firstWord (firstWord),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic doReset();
        rst       = 1'b1;
        halt      = 1'b0;
        firstWord = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Waits for SEND, samples the 80 bits and checks framing, busy and done.
    task automatic runFrame(input string tag, input int expStart,
                            input logic [63:0] expFrame, input bit disturb);
        int          waited;
        int          busyCnt;
        int          doneEarly;
        logic        firstTx;
        logic [79:0] bits;
        logic [7:0]  expByte;
        waited    = 0;
        busyCnt   = 0;
        doneEarly = 0;
        bits      = '0;
        while (busy !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            cyc++;
            waited++;
        end
        check({tag, "_sendcycle"}, 32'(cyc), 32'(expStart));
        firstTx = tx;
        for (int i = 0; i < 320; i++) begin
            if (busy === 1'b1) busyCnt++;
            if (done !== 1'b0) doneEarly++;
            if ((i % 4) == 2) bits[i / 4] = tx;
            if (disturb && i == 5) begin
                halt      = ~halt;
                firstWord = ~firstWord;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_firsttx"}, {31'd0, firstTx}, 32'd0);
        check({tag, "_busycycles"}, 32'(busyCnt), 32'd320);
        check({tag, "_doneearly"}, 32'(doneEarly), 32'd0);
        check({tag, "_end"}, {29'd0, done, busy, tx}, {29'd0, 3'b101});
        for (int k = 0; k < 8; k++) begin
            expByte = expFrame[63 - 8 * k -: 8];
            check($sformatf("%s_byte%0d", tag, k), {22'd0, bits[k * 10 +: 10]},
                  {22'd0, 1'b1, expByte, 1'b0});
        end
    endtask

    initial begin
        int waited;
        rst       = 1'b1;
        halt      = 1'b0;
        firstWord = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Normal halt at cycle 37; inputs disturbed mid-frame must not matter
        waitCycles(36);
        halt      = 1'b1;
        firstWord = 16'h1234;
        runFrame("ok", 42, 64'hA5_01_12_34_00_00_00_2A, 1'b1);
        for (int i = 0; i < 6; i++) begin
            halt      = ~halt;
            firstWord = 16'($urandom);
            waitCycles(1);
        end
        check("done_hold", {29'd0, done, busy, tx}, {29'd0, 3'b101});

        // Halt dropped during confirmation
        doReset();
        waitCycles(9);
        halt      = 1'b1;
        firstWord = 16'hBEEF;
        waitCycles(2);
        halt = 1'b0;
        runFrame("deassert", 12, 64'hA5_02_BE_EF_00_00_00_0A, 1'b0);

        // Word changes during confirmation
        doReset();
        waitCycles(9);
        halt      = 1'b1;
        firstWord = 16'h00FF;
        waitCycles(3);
        firstWord = 16'h00FE;
        runFrame("wordchg", 13, 64'hA5_04_00_FF_00_00_00_0A, 1'b0);

        // No halt at all: timeout report
        doReset();
        runFrame("timeout", 1001, 64'hA5_08_00_00_00_00_03_E9, 1'b0);

        // Halt exactly at the timeout threshold cycle wins
        doReset();
        waitCycles(1000);
        halt      = 1'b1;
        firstWord = 16'h0001;
        runFrame("edgehalt", 1006, 64'hA5_01_00_01_00_00_03_EE, 1'b0);

        // Reset in the start bit of byte 3, then a clean frame
        doReset();
        waitCycles(4);
        halt      = 1'b1;
        firstWord = 16'hCAFE;
        waited    = 0;
        while (busy !== 1'b1 && waited < 100) begin
            waitCycles(1);
            waited++;
        end
        check("abort_sendcycle", 32'(cyc), 32'd10);
        repeat (121) @(negedge clk);
        check("abort_pre_tx", {31'd0, tx}, 32'd0);
        rst  = 1'b1;
        halt = 1'b0;
        @(negedge clk);
        check("abort_state", {29'd0, done, busy, tx}, {29'd0, 3'b001});
        rst = 1'b0;
        cyc = 0;
        waitCycles(19);
        halt      = 1'b1;
        firstWord = 16'h5A5A;
        runFrame("after_abort", 25, 64'hA5_01_5A_5A_00_00_00_19, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
